// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag, fill count and sticky overflow for the async FIFO.
// Define FIFO_ALMOST_FULL_EN to add the registered wafull output.
module fifo_wptr_full #(
    parameter int unsigned add_width          = 4,
    parameter int unsigned sync_stages        = 2,
    parameter int unsigned almost_full_thresh = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [add_width:0]   rptr_gray,
    output logic [add_width-1:0] w_add,
    output logic                 wclk_en,
    output logic                 wfull,
    output logic [add_width:0]   wptr_gray,
    output logic [add_width:0]   wcount,
    output logic                 wovf,
`ifdef FIFO_ALMOST_FULL_EN
    output logic                 wafull,
`endif
    input  logic                 wovf_clr
);

    if (add_width < 2) begin : g_chk_add
        $error("add_width must be >= 2");
    end
    if (sync_stages < 2) begin : g_chk_sync
        $error("sync_stages must be >= 2");
    end
    if (almost_full_thresh > (1 << add_width)) begin : g_chk_thresh
        $error("almost_full_thresh must not exceed depth");
    end

    logic [add_width:0] sync_q [sync_stages];
    logic [add_width:0] wq_rptr;
    logic [add_width:0] wq_rbin;
    logic [add_width:0] wbin_q, wbin_d;
    logic [add_width:0] wgray_d;
    logic [add_width:0] count_d;
    logic [add_width:0] full_cmp;
    logic               wen;
    logic               wfull_d;
    logic               wovf_d;

    // Plain flop chain: any logic between stages would break the single-bit-change guarantee.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(sync_stages); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < int'(sync_stages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr = sync_q[sync_stages-1];

    always_comb begin
        wq_rbin = '0;
        for (int i = 0; i <= int'(add_width); i++) begin
            wq_rbin[i] = ^(wq_rptr >> i);
        end
    end

    assign wen      = winc & ~wfull;
    assign wbin_d   = wbin_q + (add_width+1)'(wen);
    assign wgray_d  = (wbin_d >> 1) ^ wbin_d;
    assign full_cmp = {~wq_rptr[add_width:add_width-1], wq_rptr[add_width-2:0]};
    assign wfull_d  = (wgray_d == full_cmp);
    assign count_d  = wbin_d - wq_rbin;

    // Overflow set has priority over clear on the same edge.
    always_comb begin
        wovf_d = wovf;
        if (winc && wfull) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q    <= '0;
            wptr_gray <= '0;
            wfull     <= 1'b0;
            wcount    <= '0;
            wovf      <= 1'b0;
        end else begin
            wbin_q    <= wbin_d;
            wptr_gray <= wgray_d;
            wfull     <= wfull_d;
            wcount    <= count_d;
            wovf      <= wovf_d;
        end
    end

    assign w_add   = wbin_q[add_width-1:0];
    assign wclk_en = wen;

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [add_width:0] Depth   = (add_width+1)'(1) << add_width;
    localparam logic [add_width:0] AfLevel = Depth - (add_width+1)'(almost_full_thresh);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (count_d >= AfLevel);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (add_width=4, sync_stages=2).
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] rptr_gray;
    logic [3:0] w_add;
    logic       wclk_en;
    logic       wfull;
    logic [4:0] wptr_gray;
    logic [4:0] wcount;
    logic       wovf;
    logic       wovf_clr;
`ifdef FIFO_ALMOST_FULL_EN
    logic       wafull;
`endif

    int errors = 0;
    int checks = 0;

    fifo_wptr_full #(
        .add_width          (4),
        .sync_stages        (2),
        .almost_full_thresh (2)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .w_add     (w_add),
        .wclk_en   (wclk_en),
        .wfull     (wfull),
        .wptr_gray (wptr_gray),
        .wcount    (wcount),
        .wovf      (wovf),
`ifdef FIFO_ALMOST_FULL_EN
        .wafull    (wafull),
`endif
        .wovf_clr  (wovf_clr)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] g(input logic [4:0] x);
        return x ^ (x >> 1);
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic apply_reset();
        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = '0;
        #3;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; winc = 1'b1; wovf_clr = 1'b0; rptr_gray = '0;
        #1;
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got=%b exp=0", wfull); end
        checks++; if (wptr_gray !== 5'd0) begin errors++; $display("FAIL reset_wptr got=%h exp=0", wptr_gray); end
        checks++; if (w_add !== 4'd0) begin errors++; $display("FAIL reset_wadd got=%h exp=0", w_add); end
        checks++; if (wcount !== 5'd0) begin errors++; $display("FAIL reset_wcount got=%0d exp=0", wcount); end
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf got=%b exp=0", wovf); end
        checks++; if (wclk_en !== 1'b1) begin errors++; $display("FAIL reset_wclk_en got=%b exp=1", wclk_en); end
        winc = 1'b0;
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1;
            #1;
            checks++; if (w_add !== 4'(i) || wclk_en !== 1'b1) begin
                errors++; $display("FAIL fill_addr[%0d] got w_add=%0d en=%b exp w_add=%0d en=1", i, w_add, wclk_en, i);
            end
            tick();
            checks++; if (wptr_gray !== g(5'(i + 1)) || wcount !== 5'(i + 1)) begin
                errors++; $display("FAIL fill_ptr[%0d] got gray=%h cnt=%0d exp gray=%h cnt=%0d",
                                   i, wptr_gray, wcount, g(5'(i + 1)), i + 1);
            end
        end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", wfull); end
        #1;
        checks++; if (wclk_en !== 1'b0 || w_add !== 4'd0) begin
            errors++; $display("FAIL write17_block got en=%b w_add=%0d exp en=0 w_add=0", wclk_en, w_add);
        end
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL wovf_pre got=%b exp=0", wovf); end
        tick();
        checks++; if (wovf !== 1'b1 || wptr_gray !== 5'h18 || w_add !== 4'd0) begin
            errors++; $display("FAIL write17_ovf got ovf=%b gray=%h w_add=%0d exp ovf=1 gray=18 w_add=0",
                               wovf, wptr_gray, w_add);
        end
        winc = 1'b0;
    endtask

    task automatic test_one_read();
        rptr_gray = 5'b00001;
        tick();
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL read_edge1 wfull got=%b exp=1", wfull); end
        tick();
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL read_edge2 wfull got=%b exp=1", wfull); end
        tick();
        checks++; if (wfull !== 1'b0 || wcount !== 5'd15) begin
            errors++; $display("FAIL read_edge3 got full=%b cnt=%0d exp full=0 cnt=15", wfull, wcount);
        end
        checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL wovf_sticky got=%b exp=1", wovf); end
        winc = 1'b1;
        tick();
        winc = 1'b0;
        checks++; if (wfull !== 1'b1 || wcount !== 5'd16 || wptr_gray !== 5'h19) begin
            errors++; $display("FAIL refill got full=%b cnt=%0d gray=%h exp full=1 cnt=16 gray=19",
                               wfull, wcount, wptr_gray);
        end
    endtask

    task automatic test_ovf_clr();
        wovf_clr = 1'b1;
        tick();
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_clr1 got=%b exp=0", wovf); end
        winc = 1'b1;
        tick();
        checks++; if (wovf !== 1'b1 || wptr_gray !== 5'h19) begin
            errors++; $display("FAIL ovf_set_wins got ovf=%b gray=%h exp ovf=1 gray=19", wovf, wptr_gray);
        end
        winc = 1'b0;
        tick();
        wovf_clr = 1'b0;
        checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL ovf_clr2 got=%b exp=0", wovf); end
    endtask

    task automatic test_wrap();
        logic [4:0] rd_bin;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            rd_bin = (n >= 3) ? 5'(n - 3) : 5'd0;
            rptr_gray = g(rd_bin);
            winc = 1'b1;
            #1;
            checks++; if (w_add !== 4'(n) || wclk_en !== 1'b1) begin
                errors++; $display("FAIL wrap_addr[%0d] got w_add=%0d en=%b exp w_add=%0d en=1",
                                   n, w_add, wclk_en, n % 16);
            end
            tick();
            checks++; if (wptr_gray !== g(5'(n + 1)) || wfull !== 1'b0) begin
                errors++; $display("FAIL wrap_ptr[%0d] got gray=%h full=%b exp gray=%h full=0",
                                   n, wptr_gray, wfull, g(5'(n + 1)));
            end
        end
        winc = 1'b0;
        checks++; if (w_add !== 4'd8 || wptr_gray !== 5'h0c) begin
            errors++; $display("FAIL wrap_end got w_add=%0d gray=%h exp w_add=8 gray=0c", w_add, wptr_gray);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        winc = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (w_add !== 4'd9) begin errors++; $display("FAIL mid_pre w_add got=%0d exp=9", w_add); end
        wrst_n = 1'b0;
        #2;
        checks++; if (wfull !== 1'b0 || wptr_gray !== 5'd0 || w_add !== 4'd0 || wcount !== 5'd0 || wovf !== 1'b0) begin
            errors++; $display("FAIL mid_reset got full=%b gray=%h w_add=%0d cnt=%0d ovf=%b exp all 0",
                               wfull, wptr_gray, w_add, wcount, wovf);
        end
        wrst_n = 1'b1;
        #1;
        checks++; if (w_add !== 4'd0 || wclk_en !== 1'b1) begin
            errors++; $display("FAIL mid_resume0 got w_add=%0d en=%b exp 0/1", w_add, wclk_en);
        end
        tick();
        checks++; if (w_add !== 4'd1 || wptr_gray !== 5'd1) begin
            errors++; $display("FAIL mid_resume1 got w_add=%0d gray=%h exp 1/01", w_add, wptr_gray);
        end
        winc = 1'b0;
    endtask

`ifdef FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        apply_reset();
        checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL af_reset got=%b exp=0", wafull); end
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (wafull !== (k >= 14)) begin
                errors++; $display("FAIL af_level[%0d] got=%b exp=%b", k, wafull, k >= 14);
            end
        end
        tick();
        winc = 1'b0;
        checks++; if (wafull !== 1'b1 || wfull !== 1'b1) begin
            errors++; $display("FAIL af_hold got af=%b full=%b exp 1/1", wafull, wfull);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_one_read();
        test_ovf_clr();
        test_wrap();
        test_reset_mid();
`ifdef FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
